mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
//
// PURPOSE
//  Shares the single tagged memory port between the non-blocking icache (loads/prefetch)
//  and the dcache (loads/stores). Picks one requester per cycle and holds the grant
//  while memory is busy (response 0).
//  Records which requester owns each accepted 4-bit memory tag, then routes each
//  returned tag/data to that requester only. Sits between both caches and mem.
//
// PARAMETERS
//  MAX_WAIT   4    consecutive icache-blocked cycles before icache is forced to win (1..15)
//  NUM_TAGS   16   memory tag space; tag 0 means "no response/no data"
//
// PORTS
//  clock              in   1   system clock, rising edge
//  reset              in   1   synchronous, active-low (0 = reset)
//  icache_command     in   2   BUS_NONE/BUS_LOAD from icache (BUS_STORE is illegal here)
//  icache_addr        in   32  icache request address
//  dcache_command     in   2   BUS_NONE/BUS_LOAD/BUS_STORE from dcache
//  dcache_addr        in   32  dcache request address
//  dcache_wdata       in   64  dcache store data
//  Imem2proc_response in   4   nonzero = request accepted this cycle with that tag
//  Imem2proc_data     in   64  returned load data
//  Imem2proc_tag      in   4   nonzero = data for that tag valid this cycle
//  proc2mem_command   out  2   command to memory
//  proc2mem_addr      out  32  address to memory
//  proc2mem_data      out  64  store data to memory (dcache_wdata when D granted, else 0)
//  icache_response    out  4   Imem2proc_response when icache granted, else 0
//  icache_tag         out  4   Imem2proc_tag if the tag is owned by icache, else 0
//  dcache_response    out  4   Imem2proc_response when dcache granted, else 0
//  dcache_tag         out  4   Imem2proc_tag if the tag is owned by dcache, else 0
//  mem_data_out       out  64  Imem2proc_data broadcast to both caches
//  icache_outstanding out  5   icache loads accepted and not yet returned
//  dcache_outstanding out  5   dcache loads accepted and not yet returned
//  arb_error          out  1   sticky: orphan tag return or tag reuse while still owned
//
// BEHAVIOUR
//  Active requester: a requester is active when its command is not BUS_NONE.
//
//  Grant FSM (registered state; grant decision is combinational within the cycle):
//   FREE   : winner = icache if starve_cnt==MAX_WAIT and icache active;
//            else dcache if active; else icache if active; else none (BUS_NONE).
//            Winner's cmd/addr drive memory this cycle.
//            If Imem2proc_response==0 with a winner, go to LOCK_I or LOCK_D; else stay FREE.
//   LOCK_x : drive requester x only.
//            response!=0 -> FREE. x goes BUS_NONE (cancel) -> FREE, nothing issued.
//            The other requester's activity is ignored.
//  starve_cnt (4b): +1 (saturating at MAX_WAIT) each cycle the icache is active but not accepted.
//   Cleared when an icache request is accepted, or when the icache is inactive.
//
//  Owner table: NUM_TAGS entries of {valid, owner}; only loads allocate.
//   Returned-tag routing uses the registered table, so a tag cannot return in its accept cycle.
//   At the clock edge:
//    - returned tag T (T!=0, valid): clear entry T and decrement its owner's outstanding count.
//    - returned tag T with entry invalid: drop the data, set arb_error.
//    - accepted load with tag R: set entry R = {1, owner} and increment that owner's count.
//    - accepted store: no allocation.
//    - R already valid and not returning this cycle: overwrite the entry, set arb_error.
//    - R==T in the same cycle: clear then set (the set wins; counts remain consistent).
//  Outstanding counts are 5 bits and never exceed 16; simultaneous inc+dec = no change.
//
//  Reset (reset==0 at a clock edge): FSM=FREE, starve_cnt=0, table all invalid,
//   counts 0, arb_error 0.
//   All combinational outputs then read as BUS_NONE/0 until a requester is active.
//   Reset mid-lock drops the lock; in-flight tags are forgotten, and later returns of
//   them flag arb_error, which is acceptable only when memory is reset together with the arbiter.
//
// TESTING
//  1. Both idle -> proc2mem_command=BUS_NONE; all outputs 0; arb_error 0.
//  2. I and D load same cycle, response=3 -> D wins, dcache_response=3, icache_response=0;
//     tag 3 returns -> dcache_tag=3, icache_tag=0, dcache_outstanding 1->0.
//  3. MAX_WAIT=4, D loads every cycle, I active -> I accepted on the 5th cycle;
//     starve_cnt returns to 0.
//  4. I load, response=0 for 3 cycles while D active -> I stays granted (LOCK_I);
//     response=7 -> icache_response=7, FSM back to FREE.
//  5. D store accepted with tag 5, then tag 5 returns -> no routing, arb_error=1 (sticky until reset).
//  6. Tag 9 returns while a new I load is accepted as tag 9 -> old owner gets tag 9;
//     the entry is reset to icache; counts remain consistent; arb_error stays 0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for a tagged, non-blocking memory port.
// The grant is held while memory stalls, and returned tags are steered to the requester that issued them.
module mem_bus_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int NUM_TAGS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  icache_command,
  input  logic [31:0] icache_addr,
  input  logic [1:0]  dcache_command,
  input  logic [31:0] dcache_addr,
  input  logic [63:0] dcache_wdata,
  input  logic [3:0]  Imem2proc_response,
  input  logic [63:0] Imem2proc_data,
  input  logic [3:0]  Imem2proc_tag,
  output logic [1:0]  proc2mem_command,
  output logic [31:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  output logic [3:0]  icache_response,
  output logic [3:0]  icache_tag,
  output logic [3:0]  dcache_response,
  output logic [3:0]  dcache_tag,
  output logic [63:0] mem_data_out,
  output logic [4:0]  icache_outstanding,
  output logic [4:0]  dcache_outstanding,
  output logic        arb_error
);

  // Bus encoding: 0 = none, 1 = load, 2 = store
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam logic [3:0] MAX_WAIT_V = 4'(MAX_WAIT);

  typedef enum logic [1:0] {FREE, LOCK_I, LOCK_D} state_t;

  state_t state_reg, state_next;
  logic [3:0] starve_reg, starve_next;
  logic [NUM_TAGS-1:0] valid_reg, valid_next;
  logic [NUM_TAGS-1:0] owner_reg, owner_next;   // 1 = dcache, 0 = icache
  logic [4:0] icache_out_reg, icache_out_next;
  logic [4:0] dcache_out_reg, dcache_out_next;
  logic arb_error_reg, arb_error_next;

  logic i_act, d_act;
  logic grant_i, grant_d;
  logic mem_accept, load_accept;
  logic ret_hit, ret_owner;
  logic ovr, ovr_owner;

  assign i_act = (icache_command != BUS_NONE);
  assign d_act = (dcache_command != BUS_NONE);

  always_comb begin
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    state_next = FREE;
    case (state_reg)
      FREE: begin
        if (i_act && (starve_reg == MAX_WAIT_V)) grant_i = 1'b1;
        else if (d_act)                          grant_d = 1'b1;
        else if (i_act)                          grant_i = 1'b1;
      end
      LOCK_I:  grant_i = i_act;
      LOCK_D:  grant_d = d_act;
      default: ;
    endcase
    // A stalled grant is held; acceptance or a cancel returns to FREE.
    if (grant_i && (Imem2proc_response == 4'd0))      state_next = LOCK_I;
    else if (grant_d && (Imem2proc_response == 4'd0)) state_next = LOCK_D;
  end

  assign proc2mem_command = grant_i ? icache_command : (grant_d ? dcache_command : BUS_NONE);
  assign proc2mem_addr    = grant_i ? icache_addr : (grant_d ? dcache_addr : 32'd0);
  assign proc2mem_data    = grant_d ? dcache_wdata : 64'd0;
  assign icache_response  = grant_i ? Imem2proc_response : 4'd0;
  assign dcache_response  = grant_d ? Imem2proc_response : 4'd0;
  assign mem_data_out     = Imem2proc_data;

  assign mem_accept  = (grant_i || grant_d) && (Imem2proc_response != 4'd0);
  assign load_accept = mem_accept && (proc2mem_command == BUS_LOAD);

  always_comb begin
    starve_next = starve_reg;
    if (!i_act || (grant_i && mem_accept)) starve_next = 4'd0;
    else if (starve_reg < MAX_WAIT_V)      starve_next = starve_reg + 4'd1;
  end

  // Routing looks at the registered table only, so a tag never returns in its accept cycle.
  assign ret_hit    = (Imem2proc_tag != 4'd0) && valid_reg[Imem2proc_tag];
  assign ret_owner  = owner_reg[Imem2proc_tag];
  assign icache_tag = (ret_hit && !ret_owner) ? Imem2proc_tag : 4'd0;
  assign dcache_tag = (ret_hit &&  ret_owner) ? Imem2proc_tag : 4'd0;

  assign ovr = load_accept && valid_reg[Imem2proc_response] &&
               !(ret_hit && (Imem2proc_tag == Imem2proc_response));
  assign ovr_owner = owner_reg[Imem2proc_response];

  generate
    for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : g_entry
      localparam logic [3:0] IDX = 4'(gi);
      logic set_e, clr_e;
      assign set_e = load_accept && (Imem2proc_response == IDX);
      assign clr_e = ret_hit && (Imem2proc_tag == IDX);
      assign valid_next[gi] = set_e ? 1'b1 : (clr_e ? 1'b0 : valid_reg[gi]);
      assign owner_next[gi] = set_e ? grant_d : owner_reg[gi];
    end
  endgenerate

  // An overwritten entry also retires its previous owner's count to keep counts matching the table.
  always_comb begin
    icache_out_next = icache_out_reg
                    + {4'd0, load_accept && grant_i}
                    - {4'd0, ret_hit && !ret_owner}
                    - {4'd0, ovr && !ovr_owner};
    dcache_out_next = dcache_out_reg
                    + {4'd0, load_accept && grant_d}
                    - {4'd0, ret_hit && ret_owner}
                    - {4'd0, ovr && ovr_owner};
    arb_error_next  = arb_error_reg || ovr ||
                      ((Imem2proc_tag != 4'd0) && !valid_reg[Imem2proc_tag]);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg      <= FREE;
      starve_reg     <= 4'd0;
      valid_reg      <= '0;
      owner_reg      <= '0;
      icache_out_reg <= 5'd0;
      dcache_out_reg <= 5'd0;
      arb_error_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      starve_reg     <= starve_next;
      valid_reg      <= valid_next;
      owner_reg      <= owner_next;
      icache_out_reg <= icache_out_next;
      dcache_out_reg <= dcache_out_next;
      arb_error_reg  <= arb_error_next;
    end
  end

  assign icache_outstanding = icache_out_reg;
  assign dcache_outstanding = dcache_out_reg;
  assign arb_error          = arb_error_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: grant priority, starvation, lock hold,
// store tags, orphan returns and same-cycle tag reuse.
module tb_mem_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  icache_command, dcache_command;
  logic [31:0] icache_addr, dcache_addr;
  logic [63:0] dcache_wdata;
  logic [3:0]  Imem2proc_response, Imem2proc_tag;
  logic [63:0] Imem2proc_data;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  icache_response, icache_tag, dcache_response, dcache_tag;
  logic [63:0] mem_data_out;
  logic [4:0]  icache_outstanding, dcache_outstanding;
  logic        arb_error;

  int total_cnt = 0;
  int pass_cnt  = 0;

  always #5 clock = ~clock;

  mem_bus_arbiter #(.MAX_WAIT(4), .NUM_TAGS(16)) dut (
    .clock(clock), .reset(reset),
    .icache_command(icache_command), .icache_addr(icache_addr),
    .dcache_command(dcache_command), .dcache_addr(dcache_addr),
    .dcache_wdata(dcache_wdata),
    .Imem2proc_response(Imem2proc_response), .Imem2proc_data(Imem2proc_data),
    .Imem2proc_tag(Imem2proc_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .icache_response(icache_response), .icache_tag(icache_tag),
    .dcache_response(dcache_response), .dcache_tag(dcache_tag),
    .mem_data_out(mem_data_out),
    .icache_outstanding(icache_outstanding), .dcache_outstanding(dcache_outstanding),
    .arb_error(arb_error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
      $display("check %-16s observed=%0h expected=%0h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] ic, input logic [31:0] ia,
                       input logic [1:0] dc, input logic [31:0] da, input logic [63:0] dw,
                       input logic [3:0] rsp, input logic [3:0] tg, input logic [63:0] md);
    icache_command = ic; icache_addr = ia;
    dcache_command = dc; dcache_addr = da; dcache_wdata = dw;
    Imem2proc_response = rsp; Imem2proc_tag = tg; Imem2proc_data = md;
    #2;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(2'd0, 32'd0, 2'd0, 32'd0, 64'd0, 4'd0, 4'd0, 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    tick(); tick();
    reset = 1'b1;

    // Idle after reset
    idle();
    chk("idle_cmd",    64'(proc2mem_command), 64'd0);
    chk("idle_data",   proc2mem_data, 64'd0);
    chk("idle_iresp",  64'(icache_response), 64'd0);
    chk("idle_dresp",  64'(dcache_response), 64'd0);
    chk("idle_itag",   64'(icache_tag), 64'd0);
    chk("idle_dtag",   64'(dcache_tag), 64'd0);
    chk("idle_iout",   64'(icache_outstanding), 64'd0);
    chk("idle_dout",   64'(dcache_outstanding), 64'd0);
    chk("idle_err",    64'(arb_error), 64'd0);
    tick();

    // Simultaneous loads: dcache wins with tag 3
    drive(2'd1, 32'h1000, 2'd1, 32'h2000, 64'hAAAA, 4'd3, 4'd0, 64'd0);
    chk("both_cmd",    64'(proc2mem_command), 64'd1);
    chk("both_addr",   64'(proc2mem_addr), 64'h2000);
    chk("both_data",   proc2mem_data, 64'hAAAA);
    chk("both_dresp",  64'(dcache_response), 64'd3);
    chk("both_iresp",  64'(icache_response), 64'd0);
    tick();
    chk("both_dout1",  64'(dcache_outstanding), 64'd1);
    chk("both_iout0",  64'(icache_outstanding), 64'd0);
    drive(2'd0, 32'd0, 2'd0, 32'd0, 64'd0, 4'd0, 4'd3, 64'h55);
    chk("ret3_dtag",   64'(dcache_tag), 64'd3);
    chk("ret3_itag",   64'(icache_tag), 64'd0);
    chk("ret3_mdata",  mem_data_out, 64'h55);
    tick();
    chk("ret3_dout0",  64'(dcache_outstanding), 64'd0);

    // Starvation: dcache wins four times (tags 11..14), icache takes the fifth (tag 15)
    for (int c = 1; c <= 5; c++) begin
      drive(2'd1, 32'h100, 2'd1, 32'h200 + 32'(c), 64'd0, 4'(10 + c), 4'd0, 64'd0);
      if (c < 5) begin
        chk("starve_dresp", 64'(dcache_response), 64'(10 + c));
        chk("starve_iresp", 64'(icache_response), 64'd0);
      end else begin
        chk("starve_iwin",  64'(icache_response), 64'd15);
        chk("starve_iaddr", 64'(proc2mem_addr), 64'h100);
        chk("starve_dlose", 64'(dcache_response), 64'd0);
      end
      tick();
    end
    chk("starve_dout",  64'(dcache_outstanding), 64'd4);
    chk("starve_iout",  64'(icache_outstanding), 64'd1);
    // Counter cleared: dcache wins again
    drive(2'd1, 32'h100, 2'd1, 32'h300, 64'd0, 4'd1, 4'd0, 64'd0);
    chk("starve_clr",   64'(dcache_response), 64'd1);
    tick();

    // Lock hold on icache while memory stalls
    idle();
    tick();
    drive(2'd1, 32'h300, 2'd0, 32'd0, 64'd0, 4'd0, 4'd0, 64'd0);
    chk("lock_a_addr",  64'(proc2mem_addr), 64'h300);
    chk("lock_a_iresp", 64'(icache_response), 64'd0);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(2'd1, 32'h300, 2'd1, 32'h400, 64'd0, 4'd0, 4'd0, 64'd0);
      chk("lock_hold_addr", 64'(proc2mem_addr), 64'h300);
      tick();
    end
    drive(2'd1, 32'h300, 2'd1, 32'h400, 64'd0, 4'd7, 4'd0, 64'd0);
    chk("lock_rel_iresp", 64'(icache_response), 64'd7);
    chk("lock_rel_dresp", 64'(dcache_response), 64'd0);
    tick();
    drive(2'd1, 32'h300, 2'd1, 32'h400, 64'd0, 4'd2, 4'd0, 64'd0);
    chk("free_again",   64'(dcache_response), 64'd2);
    tick();
    chk("lock_iout",    64'(icache_outstanding), 64'd2);
    chk("lock_dout",    64'(dcache_outstanding), 64'd6);

    // Store tag is never recorded; its return is an orphan
    idle();
    tick();
    drive(2'd0, 32'd0, 2'd2, 32'h500, 64'hDEAD, 4'd5, 4'd0, 64'd0);
    chk("st_cmd",       64'(proc2mem_command), 64'd2);
    chk("st_data",      proc2mem_data, 64'hDEAD);
    chk("st_dresp",     64'(dcache_response), 64'd5);
    tick();
    chk("st_dout",      64'(dcache_outstanding), 64'd6);
    chk("st_err0",      64'(arb_error), 64'd0);
    drive(2'd0, 32'd0, 2'd0, 32'd0, 64'd0, 4'd0, 4'd5, 64'h77);
    chk("orph_dtag",    64'(dcache_tag), 64'd0);
    chk("orph_itag",    64'(icache_tag), 64'd0);
    tick();
    chk("orph_err1",    64'(arb_error), 64'd1);
    idle();
    tick();
    chk("orph_sticky",  64'(arb_error), 64'd1);

    // Reset clears everything
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst_err",      64'(arb_error), 64'd0);
    chk("rst_iout",     64'(icache_outstanding), 64'd0);
    chk("rst_dout",     64'(dcache_outstanding), 64'd0);

    // Tag 9 returns to dcache while icache is accepted as tag 9
    drive(2'd0, 32'd0, 2'd1, 32'h900, 64'd0, 4'd9, 4'd0, 64'd0);
    tick();
    chk("reuse_dout1",  64'(dcache_outstanding), 64'd1);
    drive(2'd1, 32'h990, 2'd0, 32'd0, 64'd0, 4'd9, 4'd9, 64'h99);
    chk("reuse_dtag",   64'(dcache_tag), 64'd9);
    chk("reuse_itag",   64'(icache_tag), 64'd0);
    chk("reuse_iresp",  64'(icache_response), 64'd9);
    tick();
    chk("reuse_iout",   64'(icache_outstanding), 64'd1);
    chk("reuse_dout0",  64'(dcache_outstanding), 64'd0);
    chk("reuse_err",    64'(arb_error), 64'd0);
    drive(2'd0, 32'd0, 2'd0, 32'd0, 64'd0, 4'd0, 4'd9, 64'h9A);
    chk("reuse_itag2",  64'(icache_tag), 64'd9);
    chk("reuse_dtag2",  64'(dcache_tag), 64'd0);
    tick();
    chk("reuse_iout0",  64'(icache_outstanding), 64'd0);
    chk("reuse_err2",   64'(arb_error), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
